// File: rtl/half_adder_pkg.sv
// ============================================================================
// Module   : half_adder_pkg
// Purpose  : Shared constants and helpers for the lane-parallel half adder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package half_adder_pkg;

   localparam int DEFAULT_WIDTH = 1;

   // Statistics counters: width and the value at which they stop counting.
   localparam int                   STATS_W   = 32;
   localparam logic [STATS_W-1:0]   STATS_SAT = '1;

   // Bits needed to hold a count in 0..w, i.e. $clog2(w+1) with a floor of 1.
   function automatic int cnt_width(input int w);
      int r;
      r = 1;
      while ((1 << r) < (w + 1)) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage : half_adder_pkg

`default_nettype wire

// File: rtl/ha_cell.sv
// ============================================================================
// Module   : ha_cell
// Purpose  : Single-bit combinational half adder (one lane of half_adder_unit).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ha_cell (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);

   assign s = a ^ b;
   assign c = a & b;

endmodule : ha_cell

`default_nettype wire

// File: rtl/half_adder_unit.sv
// ============================================================================
// Module   : half_adder_unit
// Purpose  : Registered WIDTH-lane half adder with valid flag and carry
//            summary. Optional HALF_ADDER_UNIT_STATS_EN adds saturating
//            op_count / carry_total statistics outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module half_adder_unit
   import half_adder_pkg::*;
#(
   parameter  int WIDTH = DEFAULT_WIDTH,
   localparam int CNT_W = cnt_width(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   output logic [WIDTH-1:0] s,
   output logic [WIDTH-1:0] c,
   output logic             carry_any,
   output logic [CNT_W-1:0] carry_cnt
`ifdef HALF_ADDER_UNIT_STATS_EN
   ,
   output logic [STATS_W-1:0] op_count,
   output logic [STATS_W-1:0] carry_total
`endif
);

   logic [WIDTH-1:0] lane_s;
   logic [WIDTH-1:0] lane_c;

   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      ha_cell u_cell (
         .a (a[i]),
         .b (b[i]),
         .s (lane_s[i]),
         .c (lane_c[i])
      );
   end

   function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
      logic [CNT_W-1:0] n;
      n = '0;
      for (int i = 0; i < WIDTH; i++) begin
         n = n + CNT_W'(v[i]);
      end
      return n;
   endfunction

   logic             out_valid_d, out_valid_q;
   logic [WIDTH-1:0] s_d,         s_q;
   logic [WIDTH-1:0] c_d,         c_q;
   logic             carry_any_d, carry_any_q;
   logic [CNT_W-1:0] carry_cnt_d, carry_cnt_q;

   // Summary is derived from the next-state carry so all outputs load together;
   // lane data is only looked at when in_valid is high.
   always_comb begin
      out_valid_d = in_valid;
      s_d         = s_q;
      c_d         = c_q;
      carry_any_d = carry_any_q;
      carry_cnt_d = carry_cnt_q;
      if (in_valid) begin
         s_d         = lane_s;
         c_d         = lane_c;
         carry_any_d = |lane_c;
         carry_cnt_d = popcount(lane_c);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         s_q         <= '0;
         c_q         <= '0;
         carry_any_q <= 1'b0;
         carry_cnt_q <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         s_q         <= s_d;
         c_q         <= c_d;
         carry_any_q <= carry_any_d;
         carry_cnt_q <= carry_cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign s         = s_q;
   assign c         = c_q;
   assign carry_any = carry_any_q;
   assign carry_cnt = carry_cnt_q;

`ifdef HALF_ADDER_UNIT_STATS_EN
   logic [STATS_W-1:0] op_count_d,    op_count_q;
   logic [STATS_W-1:0] carry_total_d, carry_total_q;
   logic [STATS_W:0]   total_sum;

   // Both counters saturate instead of wrapping.
   always_comb begin
      op_count_d    = op_count_q;
      carry_total_d = carry_total_q;
      total_sum     = {1'b0, carry_total_q} + (STATS_W+1)'(carry_cnt_d);
      if (in_valid) begin
         if (op_count_q != STATS_SAT) begin
            op_count_d = op_count_q + 1'b1;
         end
         carry_total_d = total_sum[STATS_W] ? STATS_SAT : total_sum[STATS_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_count_q    <= '0;
         carry_total_q <= '0;
      end else begin
         op_count_q    <= op_count_d;
         carry_total_q <= carry_total_d;
      end
   end

   assign op_count    = op_count_q;
   assign carry_total = carry_total_q;
`endif

endmodule : half_adder_unit

`default_nettype wire

// File: tb/tb_half_adder_unit.sv
// ============================================================================
// Module   : tb_half_adder_unit
// Purpose  : Self-checking bench for half_adder_unit (WIDTH=8 and WIDTH=1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_half_adder_unit;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       v8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       ov8;
   logic [7:0] s8, c8;
   logic       any8;
   logic [3:0] cnt8;

   logic       v1 = 1'b0;
   logic [0:0] a1 = '0, b1 = '0;
   logic       ov1;
   logic [0:0] s1, c1;
   logic       any1;
   logic [0:0] cnt1;

`ifdef HALF_ADDER_UNIT_STATS_EN
   logic [31:0] ops8, tot8, ops1, tot1;
`endif

   int errors = 0;
   int checks = 0;

   // Reference model state for the WIDTH=8 instance
   logic       m_v;
   logic [7:0] m_s, m_c;
   logic       m_any;
   logic [3:0] m_cnt;
   longint     m_ops, m_tot;
   // Reference model state for the WIDTH=1 instance
   logic       m1_v;
   logic       m1_s, m1_c;

   always #5 clk = ~clk;

   half_adder_unit #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8),
      .out_valid(ov8), .s(s8), .c(c8), .carry_any(any8), .carry_cnt(cnt8)
`ifdef HALF_ADDER_UNIT_STATS_EN
      , .op_count(ops8), .carry_total(tot8)
`endif
   );

   half_adder_unit #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1),
      .out_valid(ov1), .s(s1), .c(c1), .carry_any(any1), .carry_cnt(cnt1)
`ifdef HALF_ADDER_UNIT_STATS_EN
      , .op_count(ops1), .carry_total(tot1)
`endif
   );

   // One clock: apply inputs on the falling edge, advance the model on the
   // rising edge, and return 1 time unit later so outputs are settled.
   task automatic cycle(input logic rn, input logic va, input logic [7:0] aa,
                        input logic [7:0] bb, input logic vo, input logic ao,
                        input logic bo);
      int n;
      @(negedge clk);
      rst_n = rn; v8 = va; a8 = aa; b8 = bb; v1 = vo; a1 = ao; b1 = bo;
      @(posedge clk);
      if (!rn) begin
         m_v = 0; m_s = 0; m_c = 0; m_any = 0; m_cnt = 0; m_ops = 0; m_tot = 0;
         m1_v = 0; m1_s = 0; m1_c = 0;
      end else begin
         m_v = va;
         if (va) begin
            m_s   = aa ^ bb;
            m_c   = aa & bb;
            n     = $countones(aa & bb);
            m_cnt = 4'(n);
            m_any = (n != 0);
            m_ops = (m_ops >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_ops + 1;
            m_tot = (m_tot + n > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_tot + n;
         end
         m1_v = vo;
         if (vo) begin
            m1_s = ao ^ bo;
            m1_c = ao & bo;
         end
      end
      #1;
   endtask

   task automatic test_reset;
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1);
         checks++;
         if ({ov8, s8, c8, any8, cnt8} !== 22'h0) begin
            errors++;
            $display("FAIL reset8 cyc%0d: got v=%b s=%h c=%h any=%b cnt=%0d, want all 0",
                     i, ov8, s8, c8, any8, cnt8);
         end
         checks++;
         if ({ov1, s1, c1, any1, cnt1} !== 5'h0) begin
            errors++;
            $display("FAIL reset1 cyc%0d: got v=%b s=%b c=%b any=%b cnt=%b, want all 0",
                     i, ov1, s1, c1, any1, cnt1);
         end
      end
   endtask

   task automatic test_truth_table;
      logic [1:0] ab;
      logic es, ec;
      for (int i = 0; i < 4; i++) begin
         ab = 2'(i);
         es = (ab == 2'b01) || (ab == 2'b10);
         ec = (ab == 2'b11);
         cycle(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, ab[1], ab[0]);
         checks++;
         if ({ov1, s1, c1, any1, cnt1} !== {1'b1, es, ec, ec, ec}) begin
            errors++;
            $display("FAIL truth a=%b b=%b: got v=%b s=%b c=%b any=%b cnt=%b, want v=1 s=%b c=%b any=%b cnt=%b",
                     ab[1], ab[0], ov1, s1, c1, any1, cnt1, es, ec, ec, ec);
         end
      end
   endtask

   task automatic test_directed;
      cycle(1'b1, 1'b1, 8'hF0, 8'h3C, 1'b0, 1'b0, 1'b0);
      checks++;
      if ({ov8, s8, c8, any8, cnt8} !== {1'b1, 8'hCC, 8'h30, 1'b1, 4'd2}) begin
         errors++;
         $display("FAIL directed F0/3C: got v=%b s=%h c=%h any=%b cnt=%0d, want v=1 s=cc c=30 any=1 cnt=2",
                  ov8, s8, c8, any8, cnt8);
      end
      cycle(1'b1, 1'b0, 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0);
      checks++;
      if ({ov8, s8, c8, cnt8} !== {1'b0, 8'hCC, 8'h30, 4'd2}) begin
         errors++;
         $display("FAIL directed pulse: got v=%b s=%h c=%h cnt=%0d, want v=0 s=cc c=30 cnt=2",
                  ov8, s8, c8, cnt8);
      end
   endtask

   task automatic test_hold;
      logic [7:0] hs, hc;
      logic [3:0] hn;
      cycle(1'b1, 1'b1, 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0);
      hs = m_s; hc = m_c; hn = m_cnt;
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, 1'b0, (i == 2) ? 8'bx : 8'($urandom), 8'($urandom),
               1'b0, 1'($urandom), 1'($urandom));
         checks++;
         if ({ov8, s8, c8, cnt8} !== {1'b0, hs, hc, hn}) begin
            errors++;
            $display("FAIL hold cyc%0d: got v=%b s=%h c=%h cnt=%0d, want v=0 s=%h c=%h cnt=%0d",
                     i, ov8, s8, c8, cnt8, hs, hc, hn);
         end
      end
   endtask

   task automatic test_back_to_back;
      cycle(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
      checks++;
      if ({ov8, s8, cnt8, any8} !== {1'b1, 8'h00, 4'd8, 1'b1}) begin
         errors++;
         $display("FAIL b2b first: got v=%b s=%h cnt=%0d any=%b, want v=1 s=00 cnt=8 any=1",
                  ov8, s8, cnt8, any8);
      end
      cycle(1'b1, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
      checks++;
      if ({ov8, s8, cnt8, any8} !== {1'b1, 8'hFF, 4'd0, 1'b0}) begin
         errors++;
         $display("FAIL b2b second: got v=%b s=%h cnt=%0d any=%b, want v=1 s=ff cnt=0 any=0",
                  ov8, s8, cnt8, any8);
      end
      cycle(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      checks++;
      if (ov8 !== 1'b0) begin
         errors++;
         $display("FAIL b2b end: got v=%b, want v=0", ov8);
      end
   endtask

   task automatic test_reset_wins;
      cycle(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1);
      cycle(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1);
      checks++;
      if ({ov8, c8, cnt8, ov1, c1} !== 15'h0) begin
         errors++;
         $display("FAIL reset_wins: got v8=%b c8=%h cnt8=%0d v1=%b c1=%b, want all 0",
                  ov8, c8, cnt8, ov1, c1);
      end
   endtask

   task automatic test_random;
      for (int i = 0; i < 300; i++) begin
         cycle(($urandom_range(0, 19) != 0), 1'($urandom), 8'($urandom), 8'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom));
         checks++;
         if ({ov8, s8, c8, any8, cnt8} !== {m_v, m_s, m_c, m_any, m_cnt}) begin
            errors++;
            $display("FAIL random8 #%0d: got v=%b s=%h c=%h any=%b cnt=%0d, want v=%b s=%h c=%h any=%b cnt=%0d",
                     i, ov8, s8, c8, any8, cnt8, m_v, m_s, m_c, m_any, m_cnt);
         end
         checks++;
         if ({ov1, s1, c1, any1, cnt1} !== {m1_v, m1_s, m1_c, m1_c, m1_c}) begin
            errors++;
            $display("FAIL random1 #%0d: got v=%b s=%b c=%b any=%b cnt=%b, want v=%b s=%b c=%b",
                     i, ov1, s1, c1, any1, cnt1, m1_v, m1_s, m1_c);
         end
      end
   endtask

`ifdef HALF_ADDER_UNIT_STATS_EN
   task automatic test_stats;
      cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 8'hF0, 8'h3C, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0);
      checks++;
      if (ops8 !== 32'd3 || tot8 !== 32'd10 || ops8 !== 32'(m_ops) || tot8 !== 32'(m_tot)) begin
         errors++;
         $display("FAIL stats: got op_count=%0d carry_total=%0d, want 3 and 10", ops8, tot8);
      end
      cycle(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
      checks++;
      if (ops8 !== 32'd0 || tot8 !== 32'd0) begin
         errors++;
         $display("FAIL stats_reset: got op_count=%0d carry_total=%0d, want 0 and 0", ops8, tot8);
      end
   endtask
`endif

   initial begin
      test_reset;
      test_truth_table;
      test_directed;
      test_hold;
      test_back_to_back;
      test_reset_wins;
      test_random;
`ifdef HALF_ADDER_UNIT_STATS_EN
      test_stats;
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_half_adder_unit

`default_nettype wire

// File: doc/half_adder_unit.md
Name: half_adder_unit

Overview:
- Registered, lane-parallel half adder: each of WIDTH independent bit lanes computes sum = a XOR b and carry = a AND b.
- Results are captured in output registers with a valid flag.
- Per-transfer carry summary: any-carry flag and carry population count.
- Leaf arithmetic primitive; feeds adder trees and bit-count logic downstream.

Parameters:
- WIDTH, 1, number of independent 1-bit half-adder lanes; legal range 1..64.
- CNT_W, $clog2(WIDTH+1), width of carry_cnt; derived, must not be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active low.
- in_valid  input  1  a/b valid this cycle.
- a  input  WIDTH  operand A, one bit per lane.
- b  input  WIDTH  operand B, one bit per lane.
- out_valid  output  1  s/c/carry_any/carry_cnt hold a new result.
- s  output  WIDTH  registered sum per lane.
- c  output  WIDTH  registered carry per lane.
- carry_any  output  1  OR of registered c.
- carry_cnt  output  CNT_W  number of set bits in registered c.

Behaviour:
- Reset and clocking:
  - Reset is synchronous and active-low: sampled only on the rising edge of clk.
  - While rst_n=0 at a rising edge: out_valid, s, c, carry_any and carry_cnt are all cleared to 0. in_valid is ignored.
- Per-lane function, with i in 0..WIDTH-1:
  - s[i] = a[i] ^ b[i]
  - c[i] = a[i] & b[i]
  - Lanes are fully independent; there is no carry propagation between lanes.
- Latency and capture:
  - Latency is exactly 1 cycle.
  - Edge with in_valid=1 (and rst_n=1): s, c, carry_any and carry_cnt are loaded from the current a/b, and out_valid becomes 1.
  - Edge with in_valid=0: out_valid becomes 0; s, c, carry_any and carry_cnt hold their previous values.
- No backpressure: a new transfer can be accepted every cycle, and back-to-back in_valid produces back-to-back out_valid.
- carry_any and carry_cnt are computed from the next-state carry vector and registered in the same edge as c, so all four outputs stay mutually consistent.
- carry_cnt range is 0..WIDTH. With WIDTH=1, carry_cnt is 1 bit and equals c.
- Inputs are not required to be stable when in_valid=0. X on a/b while in_valid=0 must not reach the outputs.
- Reset asserted in the same cycle as in_valid=1: reset wins and out_valid=0 on the following cycle.
- All outputs are driven directly from flops; there is no combinational path from input to output.

Optional Feature:
- Macro: HALF_ADDER_UNIT_STATS_EN
- When defined, two extra output ports are added:
  - op_count [31:0]: number of accepted transfers (in_valid=1 edges).
  - carry_total [31:0]: running sum of carry_cnt over all accepted transfers.
- Counter rules: both counters are synchronously cleared by rst_n=0 and both saturate at 32'hFFFF_FFFF (no wrap).
- carry_total updates in the same edge as the transfer that generates the carries.
- When not defined: the ports and counters do not exist, and the remaining behaviour is identical.

Decomposition:
- Package half_adder_pkg holds:
  - default WIDTH constant;
  - the function computing CNT_W;
  - the STATS counter width constant (32) and its saturation value.
- One natural sub-module: ha_cell.
  - Purely combinational single-bit half adder; inputs a, b; outputs s, c.
  - Instantiated WIDTH times with a generate loop.
- The popcount, valid register and statistics counters live in the top module.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1, a=b=all-ones -> out_valid=0, s=0, c=0, carry_any=0, carry_cnt=0 throughout.
- WIDTH=1 truth table, one pulse per cycle:
  - a/b = 0/0 -> s=0 c=0
  - 0/1 -> s=1 c=0
  - 1/0 -> s=1 c=0
  - 1/1 -> s=0 c=1, carry_cnt=1
  - each result appears 1 cycle after its input.
- WIDTH=8, a=8'hF0, b=8'h3C -> s=8'hCC, c=8'h30, carry_any=1, carry_cnt=2, out_valid=1 for exactly one cycle.
- Hold: valid transfer then in_valid=0 with random a/b for 5 cycles -> out_valid=0, s/c/carry_cnt unchanged.
- Back-to-back, WIDTH=8:
  - a=b=8'hFF, then a=8'hFF b=8'h00 on consecutive cycles;
  - -> carry_cnt=8, then 0; s=8'h00, then 8'hFF; out_valid high for 2 consecutive cycles.
- With HALF_ADDER_UNIT_STATS_EN, the three WIDTH=8 transfers above followed by reset:
  - -> op_count=3, carry_total=10;
  - both counters read 0 on the cycle after rst_n=0.
